sevenseg_scan: RTL and testbench

//   Upstream driver for the sevenseg nibble decoder. Holds a multi-digit hex value (e.g. PC
//   or a register word) and time-multiplexes it across a common-anode display: each refresh

---
 rtl/sevenseg_scan.sv | 121 ++++++++++++
 tb/tb_sevenseg_scan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Time-multiplexed hex display scanner with a shadow value that only changes at frame boundaries.
// Optional feature: define LEADING_ZERO_BLANK_EN to auto-blank digits above the top non-zero nibble.
module sevenseg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);
    localparam int              VW        = 4 * NUM_DIGITS;
    localparam int              PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [2:0]      LAST_IDX  = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [2:0]            idx_q, idx_d;
    logic [VW-1:0]         shadow_q, shadow_d;
    logic [VW-1:0]         pending_q, pending_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [NUM_DIGITS-1:0] auto_blank;
    logic [3:0]            nib_mux;

    assign tick     = (presc_q == PRESC_MAX);
    assign boundary = tick && (idx_q == LAST_IDX);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_sel[gi] = (idx_q == 3'(gi));
`ifdef LEADING_ZERO_BLANK_EN
        // Digit 0 always stays lit so a zero value still shows "0".
        if (gi == 0) begin : g_lsd
            assign auto_blank[gi] = 1'b0;
        end else begin : g_upper
            assign auto_blank[gi] = ~|shadow_q[VW-1:4*gi];
        end
`else
        assign auto_blank[gi] = 1'b0;
`endif
    end

    always_comb begin
        nib_mux = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel[i]) begin
                nib_mux = shadow_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        presc_d      = tick ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;

        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end

        if (load) begin
            pending_d    = value_in;
            pend_valid_d = 1'b1;
        end

        // A load coinciding with the boundary wins over any older pending value.
        if (boundary) begin
            if (load) begin
                shadow_d = value_in;
            end else if (pend_valid_q) begin
                shadow_d = pending_q;
            end
            pend_valid_d = 1'b0;
        end

        nibble_d     = nib_mux;
        an_d         = ~digit_sel | blank_mask | auto_blank;
        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            nibble_q     <= 4'h0;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            nibble_q     <= nibble_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble     = nibble_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: frame-by-frame scoreboard on a REFRESH_DIV=4 instance,
// plus a short hand-written sequence on a REFRESH_DIV=1 instance.
module tb_sevenseg_scan;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif
    localparam int NROWS = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, load, frame_done;
    logic [15:0] value_in;
    logic [3:0]  blank_mask, nibble, an;
    logic [2:0]  digit_idx;

    logic        rst_b, load_b, frame_done_b;
    logic [15:0] value_b;
    logic [3:0]  blank_b, nibble_b, an_b;
    logic [2:0]  digit_idx_b;

    sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .blank_mask(blank_mask), .nibble(nibble), .an(an),
        .digit_idx(digit_idx), .frame_done(frame_done)
    );

    sevenseg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_b), .value_in(value_b), .load(load_b),
        .blank_mask(blank_b), .nibble(nibble_b), .an(an_b),
        .digit_idx(digit_idx_b), .frame_done(frame_done_b)
    );

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  blank;
        logic [15:0] ans;   // expected anodes {d3,d2,d1,d0}
    } row_t;

    typedef struct packed {
        logic [3:0] nib;
        logic [3:0] an;
        logic [2:0] idx;
        logic       fd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   frame_no = 0;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
    endtask

    task automatic push_frame(input logic [15:0] val, input logic [15:0] ans);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                e.nib = val[4*d +: 4];
                e.an  = ans[4*d +: 4];
                e.idx = (c < 3) ? 3'(d) : 3'((d + 1) % 4);
                e.fd  = (d == 3) && (c == 3);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow cycle=%0d got=empty want=entry", cyc);
        end else begin
            e = sb_q.pop_front();
            check("nibble", cyc, 32'(nibble), 32'(e.nib));
            check("an", cyc, 32'(an), 32'(e.an));
            check("digit_idx", cyc, 32'(digit_idx), 32'(e.idx));
            check("frame_done", cyc, 32'(frame_done), 32'(e.fd));
        end
    endtask

    // One 16-cycle frame on u_dut; up to three loads at chosen cycles (-1 = none).
    task automatic run_frame(input logic [15:0] exp_val, input logic [15:0] exp_an,
                             input int lc0, input logic [15:0] lv0,
                             input int lc1, input logic [15:0] lv1,
                             input int lc2, input logic [15:0] lv2);
        push_frame(exp_val, exp_an);
        for (int c = 0; c < 16; c++) begin
            load = 1'b0;
            if (c == lc0) begin load = 1'b1; value_in = lv0; end
            if (c == lc1) begin load = 1'b1; value_in = lv1; end
            if (c == lc2) begin load = 1'b1; value_in = lv2; end
            @(posedge clk);
            #1;
            cyc++;
            check_pop();
        end
        load = 1'b0;
        $display("frame %0d: expected shadow=%04h an=%04h blank=%b", frame_no, exp_val, exp_an, blank_mask);
        frame_no++;
    endtask

    row_t tbl [NROWS];
    exp_t b_exp [10];

    initial begin
        tbl[0] = '{value: 16'h0000, blank: 4'b0000, ans: LZB ? 16'hFFFE : 16'h7BDE};
        tbl[1] = '{value: 16'h12AB, blank: 4'b0000, ans: 16'h7BDE};
        tbl[2] = '{value: 16'h1234, blank: 4'b0000, ans: 16'h7BDE};
        tbl[3] = '{value: 16'hFFFF, blank: 4'b0000, ans: 16'h7BDE};
        tbl[4] = '{value: 16'h00A5, blank: 4'b0000, ans: LZB ? 16'hFFDE : 16'h7BDE};
        tbl[5] = '{value: 16'hCAFE, blank: 4'b1010, ans: 16'hFBFE};
        tbl[6] = '{value: 16'h0F00, blank: 4'b0001, ans: LZB ? 16'hFBDF : 16'h7BDF};

        // REFRESH_DIV=1 instance: load 4321 out of reset, blank digit 2, reset before edge 10.
        b_exp[0] = '{idx: 3'd1, nib: 4'h0, an: 4'hE, fd: 1'b0};
        b_exp[1] = '{idx: 3'd2, nib: 4'h0, an: LZB ? 4'hF : 4'hD, fd: 1'b0};
        b_exp[2] = '{idx: 3'd3, nib: 4'h0, an: 4'hF, fd: 1'b0};
        b_exp[3] = '{idx: 3'd0, nib: 4'h0, an: LZB ? 4'hF : 4'h7, fd: 1'b1};
        b_exp[4] = '{idx: 3'd1, nib: 4'h1, an: 4'hE, fd: 1'b0};
        b_exp[5] = '{idx: 3'd2, nib: 4'h2, an: 4'hD, fd: 1'b0};
        b_exp[6] = '{idx: 3'd3, nib: 4'h3, an: 4'hF, fd: 1'b0};
        b_exp[7] = '{idx: 3'd0, nib: 4'h4, an: 4'h7, fd: 1'b1};
        b_exp[8] = '{idx: 3'd1, nib: 4'h1, an: 4'hE, fd: 1'b0};
        b_exp[9] = '{idx: 3'd0, nib: 4'h0, an: 4'hF, fd: 1'b0};

        rst_n = 1'b0; load = 1'b0; value_in = '0; blank_mask = '0;
        rst_b = 1'b0; load_b = 1'b0; value_b = '0; blank_b = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_an", cyc, 32'(an), 32'h0000000F);
        check("reset_nibble", cyc, 32'(nibble), 32'h0);
        check("reset_digit_idx", cyc, 32'(digit_idx), 32'h0);
        check("reset_frame_done", cyc, 32'(frame_done), 32'h0);
        $display("reset: an=%b nibble=%h idx=%0d fd=%b", an, nibble, digit_idx, frame_done);
        rst_n = 1'b1;

        // Each row is loaded mid-frame (digit 1 slot) and must appear whole in the next frame.
        for (int f = 0; f <= NROWS; f++) begin
            int row;
            row = (f == 0) ? 0 : f - 1;
            blank_mask = tbl[row].blank;
            run_frame(tbl[row].value, tbl[row].ans,
                      (f < NROWS) ? 5 : -1, (f < NROWS) ? tbl[f].value : 16'h0,
                      -1, 16'h0, -1, 16'h0);
        end

        // Last-wins then bypass on the boundary cycle.
        run_frame(tbl[NROWS-1].value, tbl[NROWS-1].ans, 2, 16'h0001, 8, 16'h0002, 15, 16'h0003);
        check("pend_valid_after_bypass", cyc, 32'(u_dut.pend_valid_q), 32'h0);
        blank_mask = 4'b0000;
        run_frame(16'h0003, LZB ? 16'hFFFE : 16'h7BDE, -1, 16'h0, -1, 16'h0, -1, 16'h0);
        run_frame(16'h0003, LZB ? 16'hFFFE : 16'h7BDE, -1, 16'h0, -1, 16'h0, -1, 16'h0);
        check("scoreboard_drained", cyc, 32'(sb_q.size()), 32'h0);

        rst_b = 1'b1; value_b = 16'h4321; blank_b = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            load_b = (i == 0);
            if (i == 9) rst_b = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            check("div1_digit_idx", cyc, 32'(digit_idx_b), 32'(b_exp[i].idx));
            check("div1_nibble", cyc, 32'(nibble_b), 32'(b_exp[i].nib));
            check("div1_an", cyc, 32'(an_b), 32'(b_exp[i].an));
            check("div1_frame_done", cyc, 32'(frame_done_b), 32'(b_exp[i].fd));
            $display("div1 step %0d: idx=%0d nibble=%h an=%b fd=%b", i, digit_idx_b, nibble_b, an_b, frame_done_b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
